// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the pipelined branch comparator.
//   F3_*        : RISC-V B-type funct3 encodings
//   s1_ctrl_t   : width-independent part of the stage-1 payload
//                 (operand sign bits and the branch condition)
package branch_cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       sa;
        logic       sb;
        logic [2:0] funct3;
    } s1_ctrl_t;

endpackage

// File: rtl/branch_cmp_pipe_chunk.sv
// One CHUNK-wide slice of the first comparator stage (purely combinational).
//   a, b : operand slices
//   eq   : a == b
//   ltu  : a < b, unsigned
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             ltu
);

    assign eq  = (a == b);
    assign ltu = (a < b);

endmodule

// File: rtl/branch_cmp_pipe.sv
// Two-stage valid/ready branch comparator for the execute stage.
// Stage 1 compares CHUNK-wide slices in parallel; stage 2 merges them into
// EQ / LTU / LTS and decodes the B-type condition.
//   clk, rst          : clock, async active-high reset
//   flush             : kills everything in flight at the next edge
//   in_valid/in_ready : operand handshake (in_ready is combinational from out_ready)
//   in_a, in_b        : rs1 / rs2
//   in_funct3, in_tag : branch condition and pass-through sideband tag
//   out_valid/out_ready : result handshake
//   out_taken, out_eq, out_lt, out_illegal, out_tag : registered result
module branch_cmp_pipe
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_funct3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Reduction tree is built over a power-of-two width; pad leaves are 1.
    localparam int NPOW   = 1 << $clog2(NCHUNK);

    logic [NCHUNK-1:0] eq_c;
    logic [NCHUNK-1:0] ltu_c;

    logic              s1_valid;
    logic [NCHUNK-1:0] s1_eq;
    logic [NCHUNK-1:0] s1_ltu;
    s1_ctrl_t          s1_ctrl;
    logic [TAG_W-1:0]  s1_tag;

    logic adv1, adv2;

    logic [NPOW-1:0] eq_pad;
    logic            eq_all;
    logic            ltu_sel;
    logic            lts;
    logic            taken_d;
    logic            lt_d;
    logic            illegal_d;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a   (in_a[g*CHUNK +: CHUNK]),
            .b   (in_b[g*CHUNK +: CHUNK]),
            .eq  (eq_c[g]),
            .ltu (ltu_c[g])
        );
    end

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_eq    <= '0;
            s1_ltu   <= '0;
            s1_ctrl  <= '0;
            s1_tag   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv1) begin
                s1_eq          <= eq_c;
                s1_ltu         <= ltu_c;
                s1_ctrl.sa     <= in_a[WIDTH-1];
                s1_ctrl.sb     <= in_b[WIDTH-1];
                s1_ctrl.funct3 <= in_funct3;
                s1_tag         <= in_tag;
            end
        end
    end

    // Pairwise AND, halving each level, so depth is log2(NCHUNK).
    function automatic logic and_tree(input logic [NPOW-1:0] v);
        logic [NPOW-1:0] t;
        t = v;
        for (int w = NPOW / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                t[i] = t[2*i] & t[2*i+1];
            end
        end
        return t[0];
    endfunction

    always_comb begin
        eq_pad               = '1;
        eq_pad[NCHUNK-1:0]   = s1_eq;
        eq_all               = and_tree(eq_pad);

        // Later iterations overwrite earlier ones, so the most-significant
        // differing chunk decides.
        ltu_sel = 1'b0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (!s1_eq[k]) ltu_sel = s1_ltu[k];
        end

        lts = (s1_ctrl.sa != s1_ctrl.sb) ? (s1_ctrl.sa & ~s1_ctrl.sb) : ltu_sel;

        taken_d   = 1'b0;
        lt_d      = ltu_sel;
        illegal_d = 1'b0;
        case (s1_ctrl.funct3)
            F3_BEQ:  taken_d = eq_all;
            F3_BNE:  taken_d = ~eq_all;
            F3_BLT:  begin taken_d = lts;  lt_d = lts; end
            F3_BGE:  begin taken_d = ~lts; lt_d = lts; end
            F3_BLTU: taken_d = ltu_sel;
            F3_BGEU: taken_d = ~ltu_sel;
            default: begin illegal_d = 1'b1; lt_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_taken   <= 1'b0;
            out_eq      <= 1'b0;
            out_lt      <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (adv2) begin
                out_valid <= s1_valid;
            end
            if (adv2) begin
                out_taken   <= taken_d;
                out_eq      <= eq_all;
                out_lt      <= lt_d;
                out_illegal <= illegal_d;
                out_tag     <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_pipe.sv
module tb_branch_cmp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_funct3;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_eq;
    logic        out_lt;
    logic        out_illegal;
    logic [4:0]  out_tag;

    typedef struct {
        logic       taken;
        logic       eq;
        logic       lt;
        logic       ill;
        logic [4:0] tag;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    branch_cmp_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_funct3   (in_funct3),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_taken   (out_taken),
        .out_eq      (out_eq),
        .out_lt      (out_lt),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present one op; push the hand-computed expectation when it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [4:0] tag, input logic e_taken, input logic e_eq,
                        input logic e_lt, input logic e_ill, input bit push, input bit lat);
        exp_t e;
        int   n;
        bit   done;
        n = 0;
        done = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_funct3 = f3;
        in_tag    = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                if (push && !flush) begin
                    e.taken = e_taken; e.eq = e_eq; e.lt = e_lt; e.ill = e_ill;
                    e.tag = tag; e.acc = cyc; e.lat = lat;
                    q.push_back(e);
                end
                done = 1;
            end else if (++n > 200) begin
                n_chk++;
                n_err++;
                $display("FAIL send_timeout: tag %0d never accepted", tag);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk(nm, q.size(), 0);
    endtask

    // Monitor / scoreboard: a result is consumed when valid & ready and not being flushed.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_out: tag %0d with empty scoreboard", out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_tag",     out_tag,     e.tag);
                chk("out_taken",   out_taken,   e.taken);
                chk("out_eq",      out_eq,      e.eq);
                chk("out_lt",      out_lt,      e.lt);
                chk("out_illegal", out_illegal, e.ill);
                if (e.lat) chk("latency", cyc - e.acc, 2);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_funct3 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   out_valid,   0);
        chk("rst_taken",   out_taken,   0);
        chk("rst_eq",      out_eq,      0);
        chk("rst_lt",      out_lt,      0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_tag",     out_tag,     0);
        chk("rst_ready",   in_ready,    1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // a, b, funct3, tag, taken, eq, lt, illegal, push, latency-check
        send(32'h1234_5678, 32'h1234_5678, 3'b000, 5'd3, 1, 1, 0, 0, 1, 1);
        drain("drain_beq");
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 5'd4, 1, 0, 1, 0, 1, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 5'd5, 0, 0, 0, 0, 1, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 5'd6, 0, 0, 1, 0, 1, 0);
        send(32'h0100_00FF, 32'h00FF_FF00, 3'b110, 5'd7, 0, 0, 0, 0, 1, 0);
        send(32'h0100_00FF, 32'h00FF_FF00, 3'b001, 5'd8, 1, 0, 0, 0, 1, 0);
        send(32'h0100_00FF, 32'h00FF_FF00, 3'b111, 5'd9, 1, 0, 0, 0, 1, 0);
        send(32'h0000_0003, 32'h0000_0100, 3'b000, 5'd14, 0, 0, 1, 0, 1, 0);
        send(32'h0000_0005, 32'h0000_0007, 3'b100, 5'd15, 1, 0, 1, 0, 1, 0);
        send(32'hFFFF_FFFE, 32'hFFFF_FFFE, 3'b101, 5'd16, 1, 1, 0, 0, 1, 0);
        send(32'h0000_0001, 32'h0000_0002, 3'b010, 5'd17, 0, 0, 0, 1, 1, 0);
        send(32'h0000_0007, 32'h0000_0007, 3'b011, 5'd18, 0, 1, 0, 1, 1, 0);
        drain("drain_vectors");

        // Back-pressure: out_ready drops two cycles into a 4-op stream.
        fork
            begin
                send(32'h0000_0001, 32'h0000_0001, 3'b000, 5'd10, 1, 1, 0, 0, 1, 0);
                send(32'h0000_0002, 32'h0000_0001, 3'b110, 5'd11, 0, 0, 0, 0, 1, 0);
                send(32'h8000_0000, 32'h0000_0000, 3'b100, 5'd12, 1, 0, 1, 0, 1, 0);
                send(32'h0000_0010, 32'h0000_0020, 3'b111, 5'd13, 0, 0, 1, 0, 1, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_valid",    out_valid, 1);
                chk("stall_tag",      out_tag,   q[0].tag);
                chk("stall_taken",    out_taken, q[0].taken);
                @(negedge clk);
                chk("stall_hold_tag", out_tag,   q[0].tag);
                chk("stall_hold_eq",  out_eq,    q[0].eq);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Flush: tags 1..3 must vanish; tag 4 follows with normal latency.
        send(32'h0000_0001, 32'h0000_0001, 3'b000, 5'd1, 1, 1, 0, 0, 0, 0);
        send(32'h0000_0002, 32'h0000_0002, 3'b000, 5'd2, 1, 1, 0, 0, 0, 0);
        in_valid = 1'b1; in_tag = 5'd3; in_funct3 = 3'b000; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid0", out_valid, 0);
        @(posedge clk);
        #1;
        chk("flush_valid1", out_valid, 0);
        send(32'h0000_0009, 32'h0000_0003, 3'b101, 5'd4, 1, 0, 0, 0, 1, 1);
        drain("drain_flush");

        // Reset with two ops in flight: nothing may emerge.
        send(32'h0000_00AA, 32'h0000_00AA, 3'b000, 5'd20, 1, 1, 0, 0, 0, 0);
        send(32'h0000_0001, 32'h0000_0002, 3'b110, 5'd21, 1, 0, 1, 0, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tag",   out_tag,   0);
        chk("mid_rst_taken", out_taken, 0);
        chk("mid_rst_eq",    out_eq,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 0);
        send(32'h0000_0001, 32'h0000_0002, 3'b110, 5'd22, 1, 0, 1, 0, 1, 1);
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised, pipelined branch comparator for the RISC-V execute stage.
- Generalises the 32-bit equality tree to any WIDTH. Adds signed and unsigned less-than and all six B-type conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Two-stage valid/ready pipeline with flush; sits between operand forwarding and the branch-resolve/PC-redirect logic.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits per first-stage slice; NCHUNK = WIDTH/CHUNK, which must be ≥1.
- TAG_W, 5, width of the sideband tag (ROB/PC index) passed through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  operands presented.
- in_ready  out  1  pipeline can accept this cycle.
- in_a  in  WIDTH  rs1 value.
- in_b  in  WIDTH  rs2 value.
- in_funct3  in  3  branch condition (RISC-V funct3 encoding).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch condition true.
- out_eq  out  1  a == b.
- out_lt  out  1  a < b, signed or unsigned per funct3.
- out_illegal  out  1  funct3 is 010 or 011.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0. All out_* = 0. All stage registers = 0.
- Latency: 2 cycles from the accept edge (in_valid & in_ready) to out_valid=1 when there is no stall. Throughput is 1 result per cycle.
- Advance rules:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1. This is combinational from out_ready; no skid buffer.
- Stage 1, registered on adv1:
  - For each chunk k: eq[k] = (a_k == b_k) and ltu[k] = (a_k < b_k), unsigned.
  - Also registers sa = a[WIDTH-1], sb = b[WIDTH-1], funct3 and tag.
  - s1_valid <= in_valid.
- Stage 2, registered on adv2; s2_valid <= s1_valid.
  - EQ = AND of all eq[k], built as a balanced reduction tree.
  - LTU = ltu[j], where j is the most-significant chunk with eq[j]=0. LTU = 0 if all chunks are equal.
  - LTS = sa & ~sb when sa≠sb, else LTU.
- funct3 decode:
  - 000 → taken=EQ.
  - 001 → taken=~EQ.
  - 100 → taken=LTS.
  - 101 → taken=~LTS.
  - 110 → taken=LTU.
  - 111 → taken=~LTU.
  - 010/011 → taken=0, illegal=1, lt=0.
- out_lt = LTS for 100/101. out_lt = LTU for 110/111. out_lt = LTU for 000/001 (informational).
- Stall: when out_valid=1 and out_ready=0, every out_* and all stage-2 registers hold stable. Stage 1 holds if it is also full.
- Flush: at the next edge, s1_valid=0 and s2_valid=0.
  - Flush has priority over acceptance; an input accepted in the flush cycle is discarded.
  - Data registers may keep stale values. out_valid=0 the cycle after flush.
- Simultaneous out_ready and new input with both stages full: both advance in the same edge with no bubble.
- Reset mid-operation clears valids immediately (async). No result is emitted for entries in flight.
- WIDTH == CHUNK (NCHUNK=1) must elaborate. The priority select then degenerates to ltu[0].

Decomposition:
- Package branch_cmp_pkg holds:
  - funct3 localparams F3_BEQ=3'b000, F3_BNE=3'b001, F3_BLT=3'b100, F3_BGE=3'b101, F3_BLTU=3'b110, F3_BGEU=3'b111.
  - Typedef for the stage-1 payload struct.
- One sub-module, cmp_chunk: CHUNK-wide combinational slice producing eq and ltu. It is instantiated NCHUNK times in a generate loop.
- The reduction tree and priority select are inline in the top.

Test Plan:
- BEQ equal: a=0x1234_5678, b=0x1234_5678, funct3=000, tag=3 → two cycles later out_valid=1, taken=1, eq=1, lt=0, tag=3.
- Signed vs unsigned: a=0xFFFF_FFFF, b=0x0000_0001.
  - funct3=100 → taken=1, lt=1.
  - funct3=110 → taken=0, lt=0.
  - funct3=101 → taken=0.
- Chunk priority: a=0x0100_00FF, b=0x00FF_FF00, BLTU → taken=0. The upper chunk decides even though the lower chunk has ltu=1.
- Back-pressure: stream 4 ops back-to-back with out_ready=0 from cycle 2.
  - in_ready=0 once both stages are full; outputs held.
  - Release out_ready → 4 results in order, with no loss or duplication.
- Flush: accept ops tag=1 and tag=2, assert flush while tag=3 is presented → no out_valid for tags 1–3. The next op (tag=4) emerges 2 cycles after its accept.
- Illegal and reset: funct3=010 → illegal=1, taken=0. Asserting rst mid-stream → out_valid=0 immediately and all outputs 0.
